int_responder: RTL and testbench

INT_RESPONDER -- requirements
Module: int_responder

---
 rtl/int_responder_if.sv | 29 ++
 rtl/int_responder.sv | 126 ++++++++++++
 tb/tb_int_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/int_responder_if.sv
// ----------------------------------------------------------------------------
// int_responder_if
//   Groups the CPU-side signals seen by the interrupt responder.
//   macroscopic_pc  [31:0]  CPU macroscopic PC, compared against the trigger PC
//   m_int_addr      [31:0]  CPU interrupt-device write address
//   m_int_byteen    [3:0]   CPU interrupt-device byte enables, nonzero = write
//   interrupt               registered interrupt request back to the CPU
//   master modport: the CPU side.  slave modport: the responder.
// ----------------------------------------------------------------------------
interface int_responder_if;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;

  modport master (
    output macroscopic_pc,
    output m_int_addr,
    output m_int_byteen,
    input  interrupt
  );

  modport slave (
    input  macroscopic_pc,
    input  m_int_addr,
    input  m_int_byteen,
    output interrupt
  );
endinterface

// File: rtl/int_responder.sv
// ----------------------------------------------------------------------------
// int_responder
//   Watches the CPU PC for TRIG_PC. When it is seen, waits DELAY+1 cycles,
//   raises an interrupt, and holds it until the CPU writes the acknowledge
//   address. After an acknowledge the block stays quiet for HOLDOFF+1 cycles
//   before it can be re-armed. Once MAX_INT interrupts have been acknowledged
//   (MAX_INT != 0) it parks in DONE until reset.
//
//   clk            system clock, rising edge
//   reset          synchronous, active-low
//   bus            int_responder_if.slave (pc, ack write port, interrupt)
//   int_count      acknowledged interrupts, saturating at 255
//   spurious_ack   sticky: an acknowledge arrived while no interrupt was up
//   done           high once MAX_INT interrupts are complete
// ----------------------------------------------------------------------------
module int_responder #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter logic [31:0] TRIG_PC  = 32'h0000_3008,
  parameter logic [7:0]  DELAY    = 8'd4,
  parameter logic [7:0]  HOLDOFF  = 8'd8,
  parameter logic [7:0]  MAX_INT  = 8'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  int_responder_if.slave        bus,
  output logic [7:0]            int_count,
  output logic                  spurious_ack,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ASSERT,
    ST_HOLD,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  int_count_q, int_count_d;
  logic        spurious_q, spurious_d;
  logic        interrupt_q;
  logic        done_q;

  logic        ack;
  logic        match;

  assign ack   = (bus.m_int_addr == ACK_ADDR) && (bus.m_int_byteen != 4'b0000);
  assign match = (bus.macroscopic_pc == TRIG_PC);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_count_d = int_count_q;
    // Any acknowledge that does not retire a live interrupt is spurious; it
    // only sets the flag and leaves the sequence untouched.
    spurious_d  = spurious_q | (ack && (state_q != ST_ASSERT));

    unique case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d = ST_WAIT;
          cnt_d   = DELAY;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) state_d = ST_ASSERT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_ASSERT: begin
        if (ack) begin
          state_d = ST_HOLD;
          cnt_d   = HOLDOFF;
          if (int_count_q != 8'hFF) int_count_d = int_count_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          // int_count already includes the acknowledge that entered HOLD.
          if ((MAX_INT != 8'd0) && (int_count_q == MAX_INT)) state_d = ST_DONE;
          else                                                state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      int_count_q <= 8'd0;
      spurious_q  <= 1'b0;
      interrupt_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      int_count_q <= int_count_d;
      spurious_q  <= spurious_d;
      // Outputs are registered copies of the next state, so they line up
      // with state_q and have no combinational path from the inputs.
      interrupt_q <= (state_d == ST_ASSERT);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign bus.interrupt = interrupt_q;
  assign int_count     = int_count_q;
  assign spurious_ack  = spurious_q;
  assign done          = done_q;

endmodule

// File: tb/tb_int_responder.sv
// ----------------------------------------------------------------------------
// tb_int_responder
//   Drives three differently parameterised responders from one shared CPU
//   stimulus and compares every output on every falling edge against a
//   timeline model: an arm at edge k means "interrupt from edge k+DELAY+1",
//   an acknowledge at edge j means "quiet until edge j+HOLDOFF+1".
// ----------------------------------------------------------------------------
module tb_int_responder;

  localparam int N = 3;
  localparam logic [31:0] ACK_A  = 32'h0000_7F20;
  localparam logic [31:0] TRIG_A = 32'h0000_3008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, addr;
  logic [3:0]  be;

  always #5 clk = ~clk;

  int_responder_if bus0 ();
  int_responder_if bus1 ();
  int_responder_if bus2 ();

  assign bus0.macroscopic_pc = pc;
  assign bus0.m_int_addr     = addr;
  assign bus0.m_int_byteen   = be;
  assign bus1.macroscopic_pc = pc;
  assign bus1.m_int_addr     = addr;
  assign bus1.m_int_byteen   = be;
  assign bus2.macroscopic_pc = pc;
  assign bus2.m_int_addr     = addr;
  assign bus2.m_int_byteen   = be;

  logic       intr_w [N];
  logic [7:0] cnt_w  [N];
  logic       spur_w [N];
  logic       done_w [N];

  assign intr_w[0] = bus0.interrupt;
  assign intr_w[1] = bus1.interrupt;
  assign intr_w[2] = bus2.interrupt;

  // Defaults: DELAY 4, HOLDOFF 8, MAX_INT 1.
  int_responder dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0.slave),
    .int_count(cnt_w[0]), .spurious_ack(spur_w[0]), .done(done_w[0])
  );

  // Back-to-back rounds, unlimited interrupts.
  int_responder #(.DELAY(8'd0), .HOLDOFF(8'd0), .MAX_INT(8'd0)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1.slave),
    .int_count(cnt_w[1]), .spurious_ack(spur_w[1]), .done(done_w[1])
  );

  int_responder #(.DELAY(8'd2), .HOLDOFF(8'd3), .MAX_INT(8'd3)) dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2.slave),
    .int_count(cnt_w[2]), .spurious_ack(spur_w[2]), .done(done_w[2])
  );

  function automatic int p_delay(int i);
    case (i) 0: return 4; 1: return 0; default: return 2; endcase
  endfunction
  function automatic int p_hold(int i);
    case (i) 0: return 8; 1: return 0; default: return 3; endcase
  endfunction
  function automatic int p_max(int i);
    case (i) 0: return 1; 1: return 0; default: return 3; endcase
  endfunction

  // ---------------- reference timeline model ----------------
  int  edge_n = 0;
  bit  live = 1'b0;
  bit  m_armed     [N];
  int  m_int_start [N];
  int  m_quiet_end [N];
  bit  m_done_pend [N];
  int  m_done_edge [N];
  int  m_count     [N];
  bit  m_spur      [N];

  always @(posedge clk) begin
    bit m_match, m_ack;
    edge_n++;
    m_match = (pc == TRIG_A);
    m_ack   = (addr == ACK_A) && (be != 4'd0);
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_armed[i]     = 1'b0;
        m_int_start[i] = 0;
        m_quiet_end[i] = -1;
        m_done_pend[i] = 1'b0;
        m_done_edge[i] = 0;
        m_count[i]     = 0;
        m_spur[i]      = 1'b0;
      end else if (m_done_pend[i] && edge_n > m_done_edge[i]) begin
        if (m_ack) m_spur[i] = 1'b1;
      end else if (m_armed[i] && edge_n > m_int_start[i]) begin
        if (m_ack) begin
          m_count[i]     = (m_count[i] >= 255) ? 255 : m_count[i] + 1;
          m_armed[i]     = 1'b0;
          m_quiet_end[i] = edge_n + p_hold(i) + 1;
          if (p_max(i) != 0 && m_count[i] == p_max(i)) begin
            m_done_pend[i] = 1'b1;
            m_done_edge[i] = m_quiet_end[i];
          end
        end
      end else if (m_armed[i] || edge_n <= m_quiet_end[i]) begin
        if (m_ack) m_spur[i] = 1'b1;
      end else begin
        if (m_ack) m_spur[i] = 1'b1;
        if (m_match) begin
          m_armed[i]     = 1'b1;
          m_int_start[i] = edge_n + p_delay(i) + 1;
        end
      end
    end
    if (!rst_n) live = 1'b1;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("dut%0d.interrupt", i), 32'(intr_w[i]),
              32'(m_armed[i] && edge_n >= m_int_start[i]));
        check($sformatf("dut%0d.int_count", i), 32'(cnt_w[i]), 32'(m_count[i]));
        check($sformatf("dut%0d.spurious_ack", i), 32'(spur_w[i]), 32'(m_spur[i]));
        check($sformatf("dut%0d.done", i), 32'(done_w[i]),
              32'(m_done_pend[i] && edge_n >= m_done_edge[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] pc_v, input logic [31:0] addr_v, input logic [3:0] be_v);
    pc   = pc_v;
    addr = addr_v;
    be   = be_v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc    = 32'd0;
    addr  = 32'd0;
    be    = 4'd0;
    idle(2);
    rst_n = 1'b1;

    // Single trigger, interrupt held with no acknowledge.
    idle(6);
    step(TRIG_A, 32'd0, 4'd0);
    idle(25);
    // Near misses while asserted, then a real acknowledge.
    step(32'd0, ACK_A + 32'd4, 4'b1111);
    step(32'd0, ACK_A, 4'b0000);
    idle(2);
    step(32'd0, ACK_A, 4'b1111);
    idle(14);
    // Triggers and acks after DONE are ignored / spurious.
    step(TRIG_A, ACK_A, 4'b0010);
    idle(8);

    // Acknowledge in IDLE, then match and ack together in IDLE.
    do_reset(1);
    step(32'd0, ACK_A, 4'b0001);
    idle(2);
    do_reset(1);
    step(TRIG_A, ACK_A, 4'b1000);
    idle(10);

    // Reset while asserted aborts; next trigger restarts full timing.
    do_reset(1);
    step(TRIG_A, 32'd0, 4'd0);
    idle(7);
    do_reset(1);
    idle(2);
    step(TRIG_A, 32'd0, 4'd0);
    idle(8);
    step(32'd0, ACK_A, 4'b1111);
    idle(12);

    // Continuous trigger through WAIT and HOLD.
    do_reset(1);
    for (int k = 0; k < 60; k++) begin
      if (k == 9 || k == 30 || k == 45) step(TRIG_A, ACK_A, 4'b1111);
      else                              step(TRIG_A, 32'd0, 4'd0);
    end
    idle(5);

    // Many quick rounds: drives int_count to saturation on the unlimited unit.
    do_reset(1);
    for (int r = 0; r < 262; r++) begin
      step(TRIG_A, 32'd0, 4'd0);
      idle(1);
      step(32'd0, ACK_A, 4'b1111);
      idle(1);
    end
    idle(4);

    // Randomised traffic with occasional resets.
    do_reset(1);
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] pc_r, addr_r;
      logic [3:0]  be_r;
      pc_r = ($urandom_range(0, 3) == 0) ? TRIG_A : $urandom;
      case ($urandom_range(0, 3))
        0, 1:    addr_r = ACK_A;
        2:       addr_r = ACK_A ^ (32'd1 << $urandom_range(0, 31));
        default: addr_r = $urandom;
      endcase
      be_r = ($urandom_range(0, 2) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rst_n = ($urandom_range(0, 299) != 0);
      step(pc_r, addr_r, be_r);
    end
    rst_n = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
